// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the radix-2 divide sequencer.
// Optional build macro DIV_LZC_SKIP_EN uses lead_zero_bytes() to skip leading zero bytes.
package div_ctrl_pkg;

  localparam int DIV_XLEN    = 64;
  localparam int DIV_CNT_W   = 7;
  localparam int DIV_ITER_64 = 64;
  localparam int DIV_ITER_32 = 32;

  // {is_word, is_signed, is_rem}
  typedef struct packed {
    logic is_word;
    logic is_signed;
    logic is_rem;
  } div_op_t;

  typedef enum logic [2:0] {IDLE, PREP, BUSY, FIX, DONE} div_state_t;

  // Number of all-zero bytes at the top of a left-aligned value (0..8).
  function automatic logic [3:0] lead_zero_bytes(input logic [DIV_XLEN-1:0] v);
    logic [3:0] n;
    logic       hit;
    n   = 4'd0;
    hit = 1'b0;
    for (int i = DIV_XLEN / 8 - 1; i >= 0; i--) begin
      if (!hit && (v[i*8 +: 8] == 8'd0)) n = n + 4'd1;
      else hit = 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Issue-side and writeback-side handshake bundle for the divide sequencer.
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic                in_valid;
  logic                in_ready;
  div_op_t             in_op;
  logic [DIV_XLEN-1:0] in_a;
  logic [DIV_XLEN-1:0] in_b;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [DIV_XLEN-1:0] out_data;

  // Issue logic / writeback side
  modport master (
    output in_valid, in_op, in_a, in_b, flush, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Divide controller side
  modport slave (
    input  in_valid, in_op, in_a, in_b, flush, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/div_core_u64.sv
// Unsigned restoring divider: one quotient bit per cycle for 'iters' cycles.
// The dividend arrives pre-shifted so its significant bits sit at the top.
module div_core_u64 #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] iters,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  output logic [XLEN-1:0]  q,
  output logic [XLEN-1:0]  r
);

  logic [XLEN-1:0]  q_reg;
  logic [XLEN-1:0]  r_reg;
  logic [XLEN-1:0]  d_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN:0]    r_shift;
  logic [XLEN:0]    r_diff;
  logic             fits;

  // Trial subtraction of the divisor from the partial remainder shifted by one bit.
  always_comb begin
    r_shift = {r_reg, q_reg[XLEN-1]};
    r_diff  = r_shift - {1'b0, d_reg};
    fits    = ~r_diff[XLEN];
  end

  // Load on start, then shift one quotient bit in per cycle until the count runs out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_reg   <= '0;
      r_reg   <= '0;
      d_reg   <= '0;
      cnt_reg <= '0;
    end else if (abort) begin
      cnt_reg <= '0;
    end else if (start) begin
      q_reg   <= dividend;
      r_reg   <= '0;
      d_reg   <= divisor;
      cnt_reg <= iters;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
      r_reg   <= fits ? r_diff[XLEN-1:0] : r_shift[XLEN-1:0];
      q_reg   <= {q_reg[XLEN-2:0], fits};
    end
  end

  assign q = q_reg;
  assign r = r_reg;

endmodule

// File: rtl/div_ctrl.sv
// RV64M divide/remainder sequencer: operand conditioning, special cases,
// drives div_core_u64, sign fix-up and result handshake.
// Build macro DIV_LZC_SKIP_EN: skip leading zero bytes of the dividend.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic     clk,
  input  logic     resetn,
  div_ctrl_if.slave bus
);

  div_state_t       state;
  div_op_t          op_reg;
  logic [XLEN-1:0]  a_reg, b_reg, out_data_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_q_reg, neg_r_reg, ready_reg, out_valid_reg;

  logic [XLEN-1:0]  a_ext, b_ext, abs_a, abs_b, min_val, spec_res, shifted_a;
  logic [XLEN-1:0]  core_q, core_r, fix_q, fix_r, fix_sel, fix_res;
  logic             sa, sb, div_zero, ovf, special, core_start;
  logic [CNT_W-1:0] n_iter, iters, shamt;
`ifdef DIV_LZC_SKIP_EN
  logic [XLEN-1:0]  lz_src;
  logic [CNT_W-1:0] lz_bits;
`endif

  // Condition the latched operands and classify the op while in PREP.
  always_comb begin
    a_ext = a_reg;
    b_ext = b_reg;
    if (op_reg.is_word) begin
      a_ext = {{(XLEN-32){op_reg.is_signed & a_reg[31]}}, a_reg[31:0]};
      b_ext = {{(XLEN-32){op_reg.is_signed & b_reg[31]}}, b_reg[31:0]};
    end
    sa      = op_reg.is_signed & a_ext[XLEN-1];
    sb      = op_reg.is_signed & b_ext[XLEN-1];
    abs_a   = sa ? ('0 - a_ext) : a_ext;
    abs_b   = sb ? ('0 - b_ext) : b_ext;
    min_val = op_reg.is_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    ovf      = op_reg.is_signed && (a_ext == min_val) && (b_ext == '1);
    special  = div_zero || ovf;
    if (div_zero) spec_res = op_reg.is_rem ? a_ext : '1;
    else          spec_res = op_reg.is_rem ? '0 : min_val;
    if (op_reg.is_word) spec_res = {{(XLEN-32){spec_res[31]}}, spec_res[31:0]};

    n_iter = op_reg.is_word ? CNT_W'(DIV_ITER_32) : CNT_W'(DIV_ITER_64);
    iters  = n_iter;
`ifdef DIV_LZC_SKIP_EN
    lz_src  = op_reg.is_word ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
    lz_bits = CNT_W'({lead_zero_bytes(lz_src), 3'b000});
    iters   = (lz_bits >= n_iter) ? CNT_W'(1) : (n_iter - lz_bits);
`endif
    // Left-align so the last iteration leaves a clean quotient in the low bits.
    shamt     = CNT_W'(XLEN) - iters;
    shifted_a = abs_a << shamt;
  end

  // Sign fix-up and result selection after the last core step.
  always_comb begin
    fix_q   = neg_q_reg ? ('0 - core_q) : core_q;
    fix_r   = neg_r_reg ? ('0 - core_r) : core_r;
    fix_sel = op_reg.is_rem ? fix_r : fix_q;
    fix_res = op_reg.is_word ? {{(XLEN-32){fix_sel[31]}}, fix_sel[31:0]} : fix_sel;
  end

  assign core_start = (state == PREP) && !special && !bus.flush;

  div_core_u64 #(
    .XLEN (XLEN),
    .CNT_W(CNT_W)
  ) u_core (
    .clk     (clk),
    .resetn  (resetn),
    .start   (core_start),
    .abort   (bus.flush),
    .iters   (iters),
    .dividend(shifted_a),
    .divisor (abs_b),
    .q       (core_q),
    .r       (core_r)
  );

  // Sequencing FSM with registered handshake outputs; flush overrides everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      op_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      out_data_reg  <= '0;
      cnt_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      ready_reg     <= 1'b1;
      out_valid_reg <= 1'b0;
    end else if (bus.flush) begin
      state         <= IDLE;
      cnt_reg       <= '0;
      ready_reg     <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && ready_reg) begin
            op_reg    <= bus.in_op;
            a_reg     <= bus.in_a;
            b_reg     <= bus.in_b;
            ready_reg <= 1'b0;
            state     <= PREP;
          end
        end
        PREP: begin
          neg_q_reg <= sa ^ sb;
          neg_r_reg <= sa;
          if (special) begin
            out_data_reg  <= spec_res;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            cnt_reg <= iters;
            state   <= BUSY;
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          out_data_reg  <= fix_res;
          out_valid_reg <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            ready_reg     <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready_reg & ~bus.flush;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed cases, back-pressure, flush,
// mid-op reset and randomized ops against a plain-arithmetic RV64M model.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam logic [2:0] OP_DIVU  = 3'b000, OP_REMU  = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010, OP_REM   = 3'b011;
  localparam logic [2:0] OP_DIVUW = 3'b100;
  localparam logic [2:0] OP_DIVW  = 3'b110, OP_REMW  = 3'b111;
  localparam logic [63:0] MIN64   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES64  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  div_ctrl_if bus();

  div_ctrl dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // RV64M result straight from the ISA rules.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic is_word, is_signed, is_rem;
    longint sa, sb;
    longint unsigned ua, ub;
    int sa32, sb32;
    int unsigned ua32, ub32;
    logic [31:0] r32;
    {is_word, is_signed, is_rem} = op;
    sa = a; sb = b; ua = a; ub = b;
    sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    if (is_word) begin
      if (ub32 == 0)
        r32 = is_rem ? ua32 : 32'hFFFF_FFFF;
      else if (is_signed && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
        r32 = is_rem ? 32'h0 : 32'h8000_0000;
      else if (is_signed)
        r32 = is_rem ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
      else
        r32 = is_rem ? (ua32 % ub32) : (ua32 / ub32);
      return {{32{r32[31]}}, r32};
    end
    if (ub == 0) return is_rem ? a : ONES64;
    if (is_signed && a == MIN64 && b == ONES64) return is_rem ? 64'h0 : MIN64;
    if (is_signed) return is_rem ? 64'(sa % sb) : 64'(sa / sb);
    return is_rem ? (ua % ub) : (ua / ub);
  endfunction

  // Cycles from the accept cycle to the first out_valid cycle.
  function automatic int ref_latency(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int n;
`ifdef DIV_LZC_SKIP_EN
    logic [63:0] mag;
    int lz, it;
`endif
    n = op[2] ? 32 : 64;
    if (op[2] ? (b[31:0] == 32'h0) : (b == 64'h0)) return 2;
    if (op[1] && (op[2] ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == MIN64 && b == ONES64))) return 2;
`ifdef DIV_LZC_SKIP_EN
    mag = op[2] ? (op[1] ? 64'($signed(a[31:0])) : {32'h0, a[31:0]}) : a;
    if (op[1] && mag[63]) mag = -mag;
    lz = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (mag[i]) break;
      lz++;
    end
    it = n - (lz / 8) * 8;
    if (it < 1) it = 1;
    return it + 3;
`else
    return n + 3;
`endif
  endfunction

  // Offer one op at a negedge; returns just after the accepting edge.
  task automatic launch(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    check_eq("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = {$urandom, $urandom};
    bus.in_b     = {$urandom, $urandom};
  endtask

  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat, input int hold);
    int lat;
    logic [63:0] got;
    launch(op, a, b);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 200);
    check_eq("latency", 64'(lat), 64'(exp_lat));
    got = bus.out_data;
    check_eq("out_data", got, exp);
    check_eq("in_ready_done", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
      check_eq("hold_data", bus.out_data, exp);
      check_eq("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_eq("valid_drop", 64'(bus.out_valid), 64'd0);
    check_eq("ready_back", 64'(bus.in_ready), 64'd1);
    $display("op=%0d a=%016h b=%016h result=%016h latency=%0d", op, a, b, got, lat);
  endtask

  task automatic run_ref(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input int hold);
    run_op(op, a, b, ref_result(op, a, b), ref_latency(op, a, b), hold);
  endtask

  initial begin
    logic [2:0]  op;
    logic [63:0] a, b;
    int          sel, stray;

    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_data", bus.out_data, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed cases with constant expectations.
    run_op(OP_DIVU, 64'd100, 64'd7, 64'd14, ref_latency(OP_DIVU, 64'd100, 64'd7), 0);
    run_op(OP_REMU, 64'd100, 64'd7, 64'd2, ref_latency(OP_REMU, 64'd100, 64'd7), 0);
    run_op(OP_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, ref_latency(OP_DIV, -64'sd7, 64'd2), 0);
    run_op(OP_REM, -64'sd7, 64'd2, ONES64, ref_latency(OP_REM, -64'sd7, 64'd2), 0);
    run_op(OP_DIV, 64'd5, 64'd0, ONES64, 2, 0);
    run_op(OP_REM, 64'd5, 64'd0, 64'd5, 2, 0);
    run_op(OP_REMW, 64'h1_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 2, 0);
    run_op(OP_DIV, MIN64, ONES64, MIN64, 2, 0);
    run_op(OP_REM, MIN64, ONES64, 64'd0, 2, 0);
    run_op(OP_DIVW, 64'h8000_0000, ONES64, 64'hFFFF_FFFF_8000_0000, 2, 0);
    run_op(OP_DIVUW, 64'hFFFF_FFFF_0000_0010, 64'd2, 64'd8,
           ref_latency(OP_DIVUW, 64'hFFFF_FFFF_0000_0010, 64'd2), 0);

    // Back-pressure: result held for 10 cycles.
    run_op(OP_DIVU, 64'd1000, 64'd10, 64'd100, ref_latency(OP_DIVU, 64'd1000, 64'd10), 10);

    // Randomized ops against the model.
    for (int k = 0; k < 40; k++) begin
      op  = 3'($urandom_range(0, 7));
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      sel = $urandom_range(0, 5);
      case (sel)
        0: b = op[2] ? {$urandom, 32'h0} : 64'h0;
        1: begin
          a = op[2] ? {$urandom, 32'h8000_0000} : MIN64;
          b = op[2] ? {$urandom, 32'hFFFF_FFFF} : ONES64;
        end
        2: begin
          a = 64'($urandom_range(0, 1000));
          b = 64'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        3: b = {32'h0, $urandom} >> $urandom_range(0, 31);
        default: ;
      endcase
      run_ref(op, a, b, $urandom_range(0, 3));
    end

    // Flush in BUSY cycle 20.
    launch(OP_DIVU, 64'd1000, 64'd3);
    repeat (21) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check_eq("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check_eq("flush_valid", 64'(bus.out_valid), 64'd0);
    check_eq("flush_idle", 64'(bus.in_ready), 64'd1);

    // Flush beats a simultaneous offer in IDLE.
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_DIVU;
    bus.in_a     = 64'd77;
    bus.in_b     = 64'd7;
    #1;
    check_eq("flush_blocks_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    stray = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.out_valid || !bus.in_ready) stray++;
    end
    check_eq("no_stray_result", 64'(stray), 64'd0);
    run_op(OP_DIVU, 64'd9, 64'd3, 64'd3, ref_latency(OP_DIVU, 64'd9, 64'd3), 0);

    // Flush beats out_ready in DONE.
    launch(OP_DIV, 64'd5, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("done_valid", 64'(bus.out_valid), 64'd1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_eq("done_flush_valid", 64'(bus.out_valid), 64'd0);
    check_eq("done_flush_ready", 64'(bus.in_ready), 64'd1);
    run_op(OP_DIVU, 64'd9, 64'd3, 64'd3, ref_latency(OP_DIVU, 64'd9, 64'd3), 0);

    // Asynchronous reset in the middle of an op.
    launch(OP_DIVU, 64'd50, 64'd5);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("midrst_ready", 64'(bus.in_ready), 64'd1);
    check_eq("midrst_data", bus.out_data, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op(OP_REMU, 64'd50, 64'd7, 64'd1, ref_latency(OP_REMU, 64'd50, 64'd7), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller for the iterative radix-2 unsigned divider in the execute stage.
- Accepts RV64M divide/remainder ops (DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW) from the issue logic over a valid/ready handshake.
- Conditions operands (sign handling, word trimming), handles special cases without iterating, drives the divider core, applies sign fix-up and returns one 64-bit result to writeback.

Parameters:
- XLEN, 64, datapath width.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  op offered.
- in_ready  out  1  controller can accept this cycle.
- in_op  in  3  div_op_t: {is_word, is_signed, is_rem}.
- in_a  in  XLEN  dividend (rs1).
- in_b  in  XLEN  divisor (rs2).
- flush  in  1  pipeline kill; abort the in-flight op.
- out_valid  out  1  result available.
- out_ready  in  1  writeback consumes result.
- out_data  out  XLEN  quotient or remainder, per op.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, counter=0. Reset mid-operation discards the op.
- Clock and reset: single clk domain. resetn is asynchronous active-low.
- Accept: in_valid && in_ready && !flush in cycle T latches op and operands.
- in_ready: high only in IDLE with flush low. Only one op is in flight at a time.
- States:
  - IDLE -> PREP on accept.
  - PREP (1 cycle):
    - Word ops: take bits [31:0]. Signed ops sign-extend them; unsigned ops zero-extend them.
    - Signed ops: take absolute values and record neg_q = sa^sb, neg_r = sa.
    - Divisor zero -> DONE with quotient = all-ones (XLEN bits, or 32 bits before word extension) and remainder = dividend.
    - Signed overflow (MIN / -1 at the op width) -> DONE with quotient = MIN and remainder = 0.
    - Otherwise pulse core start and go to BUSY with counter = N (N = 64, or 32 for word ops).
  - BUSY: one quotient bit per cycle; counter decrements. At counter==1 go to FIX.
  - FIX: negate the quotient if neg_q and the remainder if neg_r. Select the quotient or remainder. Word ops sign-extend bit 31 to XLEN (this includes DIVUW/REMUW). Register into out_data, then go to DONE.
  - DONE: out_valid=1 with out_data held stable. On out_ready go to IDLE; out_valid drops on the next edge.
- Latency: normal op has out_valid first high at T+N+3 (67 cycles for 64-bit ops, 35 for word ops). Special cases reach out_valid at T+2.
- Back-pressure: DONE persists indefinitely while out_ready=0.
- Flush:
  - In any state, flush forces IDLE at the next edge, clears out_valid and aborts the core.
  - Flush wins over a simultaneous accept or out_ready; the result is not delivered.
- Accept while DONE is impossible (in_ready=0); no overlap between result and next op.
- The core never sees an operand of zero divisor. Operand changes on in_a/in_b after accept are ignored.

Optional Feature:
- Macro DIV_LZC_SKIP_EN.
- Defined:
  - In PREP, count leading zeros of the conditioned dividend within the op width, rounded down to a multiple of 8 (L).
  - Pre-shift the dividend left by L and start BUSY with counter = N-L, minimum 1. Dividend zero uses N-L = 1.
  - Latency becomes T+N-L+3. Results are identical.
- Undefined: fixed N iterations. Latency is data-independent.

Decomposition:
- Shared package (pipes): div_op_t struct {is_word, is_signed, is_rem}; div_state_t enum {IDLE, PREP, BUSY, FIX, DONE}; constants DIV_ITER_64=64 and DIV_ITER_32=32.
- One sub-module, div_core_u64: start/abort/iters inputs, one restoring step per cycle, outputs q and r.
- div_ctrl holds the FSM, operand conditioning, special cases, fix-up and the handshake.

Test Plan:
- DIVU a=100, b=7 -> out_data 14 at T+67. REMU same operands -> 2.
- DIV a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). REM same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIV a=5, b=0 -> 0xFFFF_FFFF_FFFF_FFFF at T+2. REM same operands -> 5. REMW a=0x1_8000_0000, b=0 -> 0xFFFF_FFFF_8000_0000.
- Overflow cases:
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM same operands -> 0.
  - DIVW a=0x8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000.
- DIVUW a=0xFFFF_FFFF_0000_0010, b=2 -> 0x0000_0000_0000_0008 at T+35. Upper bits of a are ignored.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0.
- Flush in BUSY cycle 20 -> IDLE next edge, no out_valid. Immediate new DIVU 9/3 -> 3.
